// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - op-code constants and controller state type for alu_md
package alu_pkg;

  localparam logic [3:0] S_ADDU = 4'b0000;
  localparam logic [3:0] S_SUBU = 4'b0001;
  localparam logic [3:0] S_ADD  = 4'b0010;
  localparam logic [3:0] S_SUB  = 4'b0011;
  localparam logic [3:0] S_AND  = 4'b0100;
  localparam logic [3:0] S_OR   = 4'b0101;
  localparam logic [3:0] S_XOR  = 4'b0110;
  localparam logic [3:0] S_NOR  = 4'b0111;
  localparam logic [3:0] S_LUI0 = 4'b1000;
  localparam logic [3:0] S_LUI1 = 4'b1001;
  localparam logic [3:0] S_SLTU = 4'b1010;
  localparam logic [3:0] S_SLT  = 4'b1011;
  localparam logic [3:0] S_SRA  = 4'b1100;
  localparam logic [3:0] S_SRL  = 4'b1101;
  localparam logic [3:0] S_SLL0 = 4'b1110;
  localparam logic [3:0] S_SLL1 = 4'b1111;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIN  = 2'b10
  } md_state_t;

endpackage

// File: rtl/alu_md_seq.sv
// rtl/alu_md_seq.sv - iterative shift-add multiplier / restoring divider with hi/lo registers
module alu_md_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       md_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

  md_state_t        state;
  logic [SHW-1:0]   count;
  logic [1:0]       op_q;
  logic             neg_res;
  logic             neg_rem;
  logic             b_zero;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;

  logic             signed_op;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_sh;
  logic [WIDTH+1:0] div_trial;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] rm_fix;

  always_comb begin
    signed_op = (md_op == MD_MULT) || (md_op == MD_DIV);
    a_neg     = signed_op && a[WIDTH-1];
    b_neg     = signed_op && b[WIDTH-1];
    mag_a     = a_neg ? -a : a;
    mag_b     = b_neg ? -b : b;
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, dvs} : '0);
    div_sh    = {acc_hi, acc_lo[WIDTH-1]};
    div_trial = {1'b0, div_sh} - {2'b00, dvs};
    prod_fix  = neg_res ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    q_fix     = neg_res ? -acc_lo : acc_lo;
    rm_fix    = neg_rem ? -acc_hi : acc_hi;
  end

  assign busy = (state != IDLE);

  // Multiply and divide share acc_hi/acc_lo: product halves, or remainder/quotient.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      count   <= '0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      op_q    <= MD_MULT;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      b_zero  <= 1'b0;
      a_q     <= '0;
      dvs     <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= RUN;
            count   <= '0;
            op_q    <= md_op;
            neg_res <= a_neg ^ b_neg;
            neg_rem <= a_neg;
            b_zero  <= (b == '0);
            a_q     <= a;
            dvs     <= mag_b;
            acc_hi  <= '0;
            acc_lo  <= mag_a;
          end
        end
        RUN: begin
          if (op_q[1]) begin
            acc_hi <= div_trial[WIDTH+1] ? div_sh[WIDTH-1:0] : div_trial[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], ~div_trial[WIDTH+1]};
          end else begin
            acc_hi <= mul_sum[WIDTH:1];
            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
          end
          count <= count + SHW'(1);
          if (count == LAST) state <= FIN;
        end
        FIN: begin
          state <= IDLE;
          done  <= 1'b1;
          count <= '0;
          if (!op_q[1]) begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end else if (b_zero) begin
            hi <= a_q;
            lo <= '1;
          end else begin
            hi <= rm_fix;
            lo <= q_fix;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/alu_md.sv
// rtl/alu_md.sv - combinational ALU with flags plus iterative multiply/divide unit
module alu_md
  import alu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       s,
  input  logic             start,
  input  logic [1:0]       md_op,
  output logic [WIDTH-1:0] r,
  output logic             zero,
  output logic             overflow,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [SHW-1:0]   shamt;

  always_comb begin
    sum      = a + b;
    diff     = a - b;
    shamt    = a[SHW-1:0];
    r        = '0;
    overflow = 1'b0;
    case (s)
      S_ADDU, S_ADD: r = sum;
      S_SUBU, S_SUB: r = diff;
      S_AND:         r = a & b;
      S_OR:          r = a | b;
      S_XOR:         r = a ^ b;
      S_NOR:         r = ~(a | b);
      S_LUI0, S_LUI1: r = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      S_SLTU:        r = {{(WIDTH-1){1'b0}}, (a < b)};
      S_SLT:         r = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      S_SRA:         r = $signed(b) >>> shamt;
      S_SRL:         r = b >> shamt;
      S_SLL0, S_SLL1: r = b << shamt;
      default:       r = '0;
    endcase
    // Only the signed add/sub codes report overflow; each on its own operation.
    if (s == S_ADD)
      overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    else if (s == S_SUB)
      overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
  end

  assign zero = (r == '0);

  alu_md_seq #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_seq (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .md_op (md_op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

endmodule
